lzx_mux_scanner: RTL
====================

Name: lzx_mux_scanner

Overview:
Parametrised successor to the team's dual 4-input selector. Provides CH independent N_IN:1 multiplexer channels, each DW bits wide, sharing one select and each gated by its own active-low enable, with registered outputs. Adds an auto-scan mode in which an internal sequencer steps the shared select through every input, producing one valid sample per cycle, with hold, one-shot/continuous operation and a done pulse. Used to serialise banks of multiplexed status or data lines into a downstream capture or display block.

Parameters:
CH, 2, number of independent mux channels (>=1)
SEL_W, 2, select width; N_IN = 2**SEL_W inputs per channel (>=1)
DW, 1, data width of each input and output lane (>=1)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
en_n  input  CH  per-channel active-low enable; bit c gates channel c
mode  input  1  0 = manual select, 1 = auto-scan
s_in  input  SEL_W  manual select (used when mode=0 and idle)
start  input  1  begins a scan when idle and mode=1
cont  input  1  1 = wrap and keep scanning; 0 = one pass then stop
hold  input  1  freezes sequencer and outputs for the cycle
d  input  CH*N_IN*DW  inputs; lane (c,i) at bits [(c*N_IN+i)*DW +: DW]
y  output  CH*DW  registered outputs; channel c at bits [c*DW +: DW]
y_valid  output  1  y holds a fresh sample this cycle
s_cur  output  SEL_W  select index that produced current y
busy  output  1  sequencer in SCAN
done  output  1  one-cycle pulse coincident with the last sample of a one-shot pass

Behaviour:
- Reset (rst_n=0 at a clk edge): y=0, y_valid=0, s_cur=0, busy=0, done=0, state IDLE. Reset mid-scan aborts immediately; no done pulse is produced.
- Lane function: sample(c,k) = en_n[c] ? 0 : d lane (c,k). Disabled channels output all-zero in every mode. en_n is sampled on the same edge as the data.
- States: IDLE, SCAN. busy = (state==SCAN), driven from registered state.
- IDLE, mode=0: every edge y <= sample(c, s_in), s_cur <= s_in, y_valid <= 1. Latency is 1 cycle from s_in/d/en_n to y. hold=1 overrides: y and s_cur keep their values and y_valid <= 0.
- IDLE, mode=1, start=0: y and s_cur are held; y_valid <= 0.
- IDLE, mode=1, start=1: state <= SCAN, internal counter k <= 0, y_valid <= 0. The first sample appears on the following edge.
- SCAN, hold=0: y <= sample(c,k), s_cur <= k, y_valid <= 1, k <= k+1 modulo N_IN.
  - If k==N_IN-1 and cont=0: state <= IDLE, done <= 1 on the same edge as the last sample.
  - If k==N_IN-1 and cont=1: k wraps to 0, remain in SCAN, no done pulse.
- SCAN, hold=1: k, y, s_cur and state are held; y_valid <= 0; done <= 0. When hold and the final step coincide, hold wins and the final step is deferred.
- cont is sampled at the final step only. Deasserting cont during a continuous scan ends the scan after the current pass completes, with a done pulse.
- mode, s_in and start are ignored while in SCAN. Mode changes take effect only in IDLE.
- done is 0 on every edge except the final one-shot step.
- SEL_W=1 gives a 2-step scan. With N_IN==1 (SEL_W=0 is illegal), SEL_W must be >=1.

Decomposition:
- Shared package lzx_mux_pkg holds:
  - state enum (IDLE, SCAN)
  - localparam function for N_IN from SEL_W
  - lane-index helper function
- One natural sub-module, lzx_mux_lane: a combinational DW-bit N_IN:1 mux with active-low enable, instantiated CH times.
- The sequencer and output registers live in the top module.

Test Plan:
(CH=2, SEL_W=2, DW=1; ch0 lanes i3..i0 = 1,0,1,0; ch1 lanes = 0,1,1,0)
- Reset: hold rst_n=0 for 2 edges with random inputs -> y=00, y_valid=0, busy=0, done=0, s_cur=0.
- Manual: mode=0, en_n=00, s_in=1 -> next edge y={ch1=1,ch0=1}, y_valid=1, s_cur=1. Then set en_n=01 -> next edge ch0=0, ch1=1.
- One-shot scan: mode=1, start pulse, cont=0 -> starting 2 edges later, y per cycle for k=0..3: ch0 = 0,1,0,1 and ch1 = 0,1,1,0. y_valid=1 for 4 cycles, done=1 only with k=3, busy then 0.
- Hold: during scan, hold=1 for 2 cycles at k=1 -> y and s_cur frozen, y_valid=0. Scan resumes at k=2, and done is delayed by 2 cycles.
- Continuous: cont=1 for 9 samples -> s_cur sequence 0,1,2,3,0,1,2,3,0 with no done. Drop cont -> scan ends after s_cur=3 with done=1.
- Abort and ignore: rst_n=0 while at k=2 -> next edge all outputs reset and no done. A start or mode=0 pulse during SCAN has no effect on the sequence.

Source files
------------

// File: rtl/lzx_mux_pkg.sv
// Shared definitions for the lzx_mux_scanner block: sequencer states and
// small index helpers used to size and slice the packed input bus.
package lzx_mux_pkg;

    // Sequencer states; the top module exposes SCAN on its busy output.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    // Number of inputs per channel for a given select width.
    function automatic int n_in_of(input int sel_w);
        return 1 << sel_w;
    endfunction

    // Bit offset of lane (c, i) inside the packed d bus.
    function automatic int lane_base(input int c, input int i, input int n_in, input int dw);
        return (c * n_in + i) * dw;
    endfunction

endpackage

// File: rtl/lzx_mux_lane.sv
// One combinational N_IN:1 multiplexer channel, DW bits wide, forced to
// zero when its active-low enable is deasserted.
module lzx_mux_lane
    import lzx_mux_pkg::*;
#(
    parameter int SEL_W = 2,
    parameter int DW    = 1,
    parameter int N_IN  = n_in_of(SEL_W)
) (
    input  logic [N_IN*DW-1:0] lanes,
    input  logic [SEL_W-1:0]   sel,
    input  logic               en_n,
    output logic [DW-1:0]      y
);

    // Select one lane by comparing against each index; a disabled channel reads zero.
    always_comb begin
        y = '0;
        if (!en_n) begin
            for (int i = 0; i < N_IN; i++) begin
                if (sel == SEL_W'(i)) begin
                    y = lanes[i*DW +: DW];
                end
            end
        end
    end

endmodule

// File: rtl/lzx_mux_scanner.sv
// CH-channel N_IN:1 multiplexer with registered outputs, a manual select
// mode and an auto-scan sequencer that walks the shared select through
// every input, one sample per cycle, with hold, one-shot/continuous
// operation and a done pulse on the last sample of a one-shot pass.
//
// Output handshake: there is no ready; y and s_cur are a sample exactly on
// the cycles where y_valid is 1, and the consumer must take it then. When
// y_valid is 0, y and s_cur keep the last sample but are not new.
module lzx_mux_scanner
    import lzx_mux_pkg::*;
#(
    parameter int CH    = 2,
    parameter int SEL_W = 2,
    parameter int DW    = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [CH-1:0]                   en_n,
    input  logic                            mode,
    input  logic [SEL_W-1:0]                s_in,
    input  logic                            start,
    input  logic                            cont,
    input  logic                            hold,
    input  logic [CH*n_in_of(SEL_W)*DW-1:0] d,
    output logic [CH*DW-1:0]                y,
    output logic                            y_valid,
    output logic [SEL_W-1:0]                s_cur,
    output logic                            busy,
    output logic                            done
);

    localparam int N_IN = n_in_of(SEL_W);
    localparam logic [SEL_W-1:0] K_LAST = {SEL_W{1'b1}};

    // Sequencer state; busy is a direct view of it.
    state_t           state;
    logic [SEL_W-1:0] k;
    logic [SEL_W-1:0] mux_sel;
    logic [CH*DW-1:0] mux_y;

    assign busy = (state == ST_SCAN);

    // The sequencer owns the select while scanning; otherwise the manual select does.
    always_comb begin
        mux_sel = s_in;
        if (state == ST_SCAN) begin
            mux_sel = k;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_lane
        lzx_mux_lane #(
            .SEL_W (SEL_W),
            .DW    (DW),
            .N_IN  (N_IN)
        ) u_lane (
            .lanes (d[lane_base(c, 0, N_IN, DW) +: N_IN*DW]),
            .sel   (mux_sel),
            .en_n  (en_n[c]),
            .y     (mux_y[c*DW +: DW])
        );
    end

    // Sequencer and output registers; done defaults low and pulses only on the final one-shot step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            k       <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            s_cur   <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!mode) begin
                        if (hold) begin
                            y_valid <= 1'b0;
                        end else begin
                            y       <= mux_y;
                            s_cur   <= s_in;
                            y_valid <= 1'b1;
                        end
                    end else begin
                        y_valid <= 1'b0;
                        if (start) begin
                            state <= ST_SCAN;
                            k     <= '0;
                        end
                    end
                end
                ST_SCAN: begin
                    if (hold) begin
                        // Freeze everything; a final step that meets hold is simply deferred.
                        y_valid <= 1'b0;
                    end else begin
                        y       <= mux_y;
                        s_cur   <= k;
                        y_valid <= 1'b1;
                        k       <= k + 1'b1;
                        if (k == K_LAST && !cont) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
